// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: accumulator FSM states, default sample width,
// and signed range helpers used by the saturating adder.
package fixed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

    // Sample width produced by the float-to-fixed converter.
    localparam int FIXED_WORD_LENGTH = 21;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fixed_sat_add.sv
// Combinational signed adder; clamps to the signed range when FIXED_ACC_SAT_EN is defined,
// otherwise wraps. Latency: 0 cycles. Backpressure: none (pure combinational).
module fixed_sat_add
    import fixed_pkg::*;
#(
    parameter int ACC_LENGTH = 32
) (
    input  logic signed [ACC_LENGTH-1:0] a_i,
    input  logic signed [ACC_LENGTH-1:0] b_i,
    output logic signed [ACC_LENGTH-1:0] sum_o,
    output logic                         ovf_o
);

    localparam int MSB = ACC_LENGTH - 1;

    logic signed [ACC_LENGTH-1:0] raw_sum;

    assign raw_sum = a_i + b_i;

`ifdef FIXED_ACC_SAT_EN
    localparam logic signed [63:0] MAX64 = sat_max(ACC_LENGTH);
    localparam logic signed [63:0] MIN64 = sat_min(ACC_LENGTH);

    logic ovf;

    // Overflow only when both operands share a sign and the result flips it.
    assign ovf = (a_i[MSB] == b_i[MSB]) && (raw_sum[MSB] != a_i[MSB]);

    always_comb begin
        sum_o = raw_sum;
        if (ovf) begin
            sum_o = a_i[MSB] ? MIN64[ACC_LENGTH-1:0] : MAX64[ACC_LENGTH-1:0];
        end
    end

    assign ovf_o = ovf;
`else
    assign sum_o = raw_sum;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/fixed_accumulator.sv
// Sums a counted run of signed samples; result 1 cycle after last sample (FIXED_ACC_SAT_EN: saturate).
// Backpressure: in_ready low outside ACCUM; result held in DONE until out_ready.
module fixed_accumulator
    import fixed_pkg::*;
#(
    parameter int WORD_LENGTH = FIXED_WORD_LENGTH,
    parameter int ACC_LENGTH  = 32,
    parameter int COUNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [COUNT_W-1:0]            count,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WORD_LENGTH-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_LENGTH-1:0]  out_sum,
    output logic                          busy,
    output logic                          overflow
);

    acc_state_t                   state_q;
    logic signed [ACC_LENGTH-1:0] acc_q;
    logic signed [ACC_LENGTH-1:0] acc_d;
    logic signed [ACC_LENGTH-1:0] in_ext;
    logic [COUNT_W-1:0]           remaining_q;
    logic                         ovf_q;
    logic                         add_ovf;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         busy_q;
    logic                         in_hs;

    assign in_ext = ACC_LENGTH'(in_data);
    assign in_hs  = in_valid && in_ready_q;

    fixed_sat_add #(
        .ACC_LENGTH (ACC_LENGTH)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (in_ext),
        .sum_o (acc_d),
        .ovf_o (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (count != '0) begin
                            remaining_q <= count;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_ACCUM;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_hs) begin
                        acc_q       <= acc_d;
                        ovf_q       <= ovf_q | add_ovf;
                        remaining_q <= remaining_q - COUNT_W'(1);
                        if (remaining_q == COUNT_W'(1)) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fixed_accumulator.sv
// Directed bench for fixed_accumulator (24-bit accumulator) with a per-cycle reference model.
// Build with or without FIXED_ACC_SAT_EN; expectations follow the macro.
module tb_fixed_accumulator;

    localparam int WL  = 21;
    localparam int AL  = 24;
    localparam int CW  = 16;
    localparam longint MAXV = (64'sd1 <<< (AL - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AL - 1));

`ifdef FIXED_ACC_SAT_EN
    localparam longint OVF_SUM  = 8388607;
    localparam longint OVF_FLAG = 1;
`else
    localparam longint OVF_SUM  = 4194284;
    localparam longint OVF_FLAG = 0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [CW-1:0]        count = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [WL-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AL-1:0] out_sum;
    logic                 busy;
    logic                 overflow;

    int n_vec = 0;
    int n_bad = 0;

    fixed_accumulator #(
        .WORD_LENGTH (WL),
        .ACC_LENGTH  (AL),
        .COUNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = collecting samples, 2 = result offered.
    int     m_phase = 0;
    int     m_left  = 0;
    longint m_sum   = 0;
    bit     m_ovf   = 0;
    bit     m_en    = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_sum   = 0;
            m_ovf   = 0;
            m_en    = 1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_sum   = 0;
                    m_ovf   = 0;
                    m_left  = int'(count);
                    m_phase = (count == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    m_sum = m_sum + longint'(in_data);
`ifdef FIXED_ACC_SAT_EN
                    if (m_sum > MAXV) begin m_sum = MAXV; m_ovf = 1; end
                    if (m_sum < MINV) begin m_sum = MINV; m_ovf = 1; end
`endif
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            logic signed [AL-1:0] exp_sum;
            exp_sum = m_sum[AL-1:0];
            chk("model_in_ready",  longint'(in_ready),  longint'(m_phase == 1));
            chk("model_out_valid", longint'(out_valid), longint'(m_phase == 2));
            chk("model_busy",      longint'(busy),      longint'(m_phase != 0));
            chk("model_overflow",  longint'(overflow),  longint'(m_ovf));
            chk("model_out_sum",   longint'(out_sum),   longint'(exp_sum));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  longint'(in_ready),  0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy",      longint'(busy),      0);
        chk("rst_overflow",  longint'(overflow),  0);
        chk("rst_out_sum",   longint'(out_sum),   0);
        reset = 1'b0;
    endtask

    task automatic do_start(input int c);
        start = 1'b1;
        count = CW'(c);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int v, input int gap);
        bit hs;
        int t;
        for (int g = 0; g < gap; g++) tick();
        in_valid = 1'b1;
        in_data  = WL'(v);
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 100) begin
            hs = in_ready;
            tick();
            t++;
        end
        in_valid = 1'b0;
        if (!hs) chk("in_hs_timeout", longint'(in_ready), 1);
    endtask

    task automatic collect(input int hold, input bit poke, input longint exp_sum, input longint exp_ovf);
        int t = 0;
        while (!out_valid && t < 200) begin
            tick();
            t++;
        end
        chk("out_valid_wait", longint'(out_valid), 1);
        chk("result_sum", longint'(out_sum), exp_sum);
        chk("result_ovf", longint'(overflow), exp_ovf);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                start = 1'b1;
                count = CW'(7);
            end
            tick();
            start = 1'b0;
            chk("held_sum", longint'(out_sum), exp_sum);
            chk("held_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_out", longint'(busy), 0);
    endtask

    task automatic basic_run(input int gap, input int hold, input bit poke);
        do_start(4);
        send(262144, gap);
        send(131072, gap);
        send(-65536, gap);
        send(524288, gap);
        collect(hold, poke, 851968, 0);
    endtask

    initial begin
        apply_reset();

        basic_run(0, 0, 1'b0);
        basic_run(3, 5, 1'b1);

        do_start(0);
        chk("zero_out_valid", longint'(out_valid), 1);
        chk("zero_out_sum",   longint'(out_sum),   0);
        collect(0, 1'b0, 0, 0);

        do_start(20);
        for (int i = 0; i < 20; i++) send(1048575, 0);
        collect(2, 1'b0, OVF_SUM, OVF_FLAG);

        do_start(4);
        send(1000, 0);
        send(2000, 0);
        apply_reset();
        basic_run(0, 0, 1'b0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
